// File: rtl/controlador_registrador.sv
// Sequencer for the 7-bit universal shift register: runs one parallel load or N-step shift per command.
// Optional feature: define CONTROLADOR_ROTATE_EN to make op 11 rotate up (d fed from q_msb).
module controlador_registrador #(
  parameter int unsigned WIDTH = 7,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [CNT_W-1:0] amount,
  input  logic [WIDTH-1:0] load_value,
  input  logic             serial_in,
  input  logic             q_msb,
  output logic             ch1,
  output logic             ch0,
  output logic             d,
  output logic [WIDTH-1:0] bits,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  localparam logic [1:0] CH_HOLD = 2'b00;
  localparam logic [1:0] CH_UP   = 2'b01;
  localparam logic [1:0] CH_DOWN = 2'b10;
  localparam logic [1:0] CH_LOAD = 2'b11;

  localparam logic [CNT_W-1:0] MAX_STEPS = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [1:0]       ch_q, ch_n;
  logic             d_q, d_n;
  logic [WIDTH-1:0] bits_q, bits_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic             rot_q, rot_n;
  logic [CNT_W-1:0] amt_clamped;

  // Requests beyond the register width run the maximum useful number of steps
  assign amt_clamped = (amount > MAX_STEPS) ? MAX_STEPS : amount;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ch_q    <= CH_HOLD;
      d_q     <= 1'b0;
      bits_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rot_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      ch_q    <= ch_n;
      d_q     <= d_n;
      bits_q  <= bits_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      rot_q   <= rot_n;
    end
  end

  // Next state plus the registered value of every output for the following cycle
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    ch_n    = CH_HOLD;
    d_n     = 1'b0;
    bits_n  = '0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    rot_n   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op == 2'b00) begin
            state_n = S_LOAD;
            ch_n    = CH_LOAD;
            bits_n  = load_value;
            busy_n  = 1'b1;
          end else if (amt_clamped == '0) begin
            state_n = S_FIN;
            done_n  = 1'b1;
          end else begin
            state_n = S_SHIFT;
            cnt_n   = amt_clamped;
            ch_n    = (op == 2'b10) ? CH_DOWN : CH_UP;
            d_n     = serial_in;
            busy_n  = 1'b1;
`ifdef CONTROLADOR_ROTATE_EN
            rot_n   = (op == 2'b11);
`endif
          end
        end
      end
      S_LOAD: begin
        state_n = S_FIN;
        done_n  = 1'b1;
      end
      S_SHIFT: begin
        cnt_n = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_n = S_FIN;
          done_n  = 1'b1;
        end else begin
          ch_n   = ch_q;
          d_n    = d_q;
          busy_n = 1'b1;
          rot_n  = rot_q;
        end
      end
      S_FIN: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign ch1  = ch_q[1];
  assign ch0  = ch_q[0];
  assign bits = bits_q;
  assign busy = busy_q;
  assign done = done_q;

`ifdef CONTROLADOR_ROTATE_EN
  // Rotation feeds the live top bit back, so it cannot be latched at command time
  assign d = rot_q ? q_msb : d_q;
`else
  logic unused_q_msb;
  logic unused_rot;
  assign unused_q_msb = q_msb;
  assign unused_rot   = rot_q;
  assign d            = d_q;
`endif

endmodule

// File: tb/tb_controlador_registrador.sv
// Directed bench for controlador_registrador with a behavioural model of the shift register.
module tb_controlador_registrador;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] op;
  logic [2:0] amount;
  logic [6:0] load_value;
  logic       serial_in;
  logic       q_msb;
  logic       ch1, ch0, d, busy, done;
  logic [6:0] bits;
  logic [6:0] sreg = 7'h00;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  controlador_registrador dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .amount(amount),
    .load_value(load_value), .serial_in(serial_in), .q_msb(q_msb),
    .ch1(ch1), .ch0(ch0), .d(d), .bits(bits), .busy(busy), .done(done)
  );

  // Universal shift register driven by the sequencer
  always @(posedge clk) begin
    case ({ch1, ch0})
      2'b01:   sreg <= {sreg[5:0], d};
      2'b10:   sreg <= {d, sreg[6:1]};
      2'b11:   sreg <= bits;
      default: sreg <= sreg;
    endcase
  end
  assign q_msb = sreg[6];

  // Issues one command and walks it to its done cycle; inputs are scrambled after acceptance.
  task automatic run_cmd(input logic [1:0] c_op, input logic [2:0] c_amt, input logic [6:0] c_val,
                         input logic c_sin, input bit poke,
                         output int lat, output int nact, output int bad);
    logic [1:0] exp_ch;
    logic       exp_d;
    exp_ch = (c_op == 2'b00) ? 2'b11 : ((c_op == 2'b10) ? 2'b10 : 2'b01);
    nact = 0;
    bad  = 0;
    @(negedge clk);
    start = 1'b1; op = c_op; amount = c_amt; load_value = c_val; serial_in = c_sin;
    @(negedge clk);
    start = 1'b0; op = ~c_op; amount = ~c_amt; load_value = ~c_val; serial_in = ~c_sin;
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      exp_d = (c_op == 2'b00) ? 1'b0 : c_sin;
`ifdef CONTROLADOR_ROTATE_EN
      if (c_op == 2'b11) exp_d = q_msb;
`endif
      if ({ch1, ch0} === exp_ch) nact++;
      else bad++;
      if (busy !== 1'b1) bad++;
      if (d !== exp_d) bad++;
      if (bits !== ((c_op == 2'b00) ? c_val : 7'h00)) bad++;
      start = poke && (lat == 2);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    if (busy !== 1'b0 || {ch1, ch0} !== 2'b00 || d !== 1'b0 || bits !== 7'h00) bad++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 2'b00; amount = 3'd0; load_value = 7'h00; serial_in = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({ch1, ch0, d, bits, busy, done} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 000", {ch1, ch0, d, bits, busy, done});
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({ch1, ch0, busy, done} !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_idle: got %b want 0000", {ch1, ch0, busy, done});
    end
  endtask

  task automatic test_load();
    int lat, nact, bad;
    run_cmd(2'b00, 3'd0, 7'h55, 1'b0, 1'b0, lat, nact, bad);
    n_cmp++;
    if (lat !== 2) begin n_fail++; $display("FAIL load_latency: got %0d want 2", lat); end
    n_cmp++;
    if (nact !== 1 || bad !== 0) begin
      n_fail++; $display("FAIL load_cycles: got %0d/%0d bad want 1/0", nact, bad);
    end
    n_cmp++;
    if (sreg !== 7'h55) begin n_fail++; $display("FAIL load_value: got %h want 55", sreg); end
  endtask

  task automatic test_shift_up();
    int lat, nact, bad;
    run_cmd(2'b00, 3'd0, 7'h01, 1'b0, 1'b0, lat, nact, bad);
    run_cmd(2'b01, 3'd3, 7'h00, 1'b0, 1'b0, lat, nact, bad);
    n_cmp++;
    if (lat !== 4) begin n_fail++; $display("FAIL up_latency: got %0d want 4", lat); end
    n_cmp++;
    if (nact !== 3 || bad !== 0) begin
      n_fail++; $display("FAIL up_cycles: got %0d/%0d bad want 3/0", nact, bad);
    end
    n_cmp++;
    if (sreg !== 7'h08) begin n_fail++; $display("FAIL up_value: got %h want 08", sreg); end
  endtask

  task automatic test_shift_down();
    int lat, nact, bad;
    run_cmd(2'b00, 3'd0, 7'h40, 1'b0, 1'b0, lat, nact, bad);
    run_cmd(2'b10, 3'd6, 7'h00, 1'b1, 1'b0, lat, nact, bad);
    n_cmp++;
    if (lat !== 7) begin n_fail++; $display("FAIL down_latency: got %0d want 7", lat); end
    n_cmp++;
    if (nact !== 6 || bad !== 0) begin
      n_fail++; $display("FAIL down_cycles: got %0d/%0d bad want 6/0", nact, bad);
    end
    n_cmp++;
    if (sreg !== 7'h7F) begin n_fail++; $display("FAIL down_value: got %h want 7f", sreg); end
  endtask

  task automatic test_rotate();
    int lat, nact, bad;
    logic [6:0] exp_v;
`ifdef CONTROLADOR_ROTATE_EN
    exp_v = 7'h03;
`else
    exp_v = 7'h02;
`endif
    run_cmd(2'b00, 3'd0, 7'h41, 1'b0, 1'b0, lat, nact, bad);
    run_cmd(2'b11, 3'd1, 7'h00, 1'b0, 1'b0, lat, nact, bad);
    n_cmp++;
    if (lat !== 2 || nact !== 1 || bad !== 0) begin
      n_fail++; $display("FAIL op11_timing: got lat %0d act %0d bad %0d want 2/1/0", lat, nact, bad);
    end
    n_cmp++;
    if (sreg !== exp_v) begin n_fail++; $display("FAIL op11_value: got %h want %h", sreg, exp_v); end
  endtask

  task automatic test_clamp();
    int lat, nact, bad;
    run_cmd(2'b00, 3'd0, 7'h01, 1'b0, 1'b0, lat, nact, bad);
    run_cmd(2'b01, 3'd7, 7'h00, 1'b0, 1'b0, lat, nact, bad);
    n_cmp++;
    if (lat !== 7 || nact !== 6 || bad !== 0) begin
      n_fail++; $display("FAIL clamp_timing: got lat %0d act %0d bad %0d want 7/6/0", lat, nact, bad);
    end
    n_cmp++;
    if (sreg !== 7'h40) begin n_fail++; $display("FAIL clamp_value: got %h want 40", sreg); end
  endtask

  task automatic test_zero_amount();
    int lat, nact, bad;
    run_cmd(2'b00, 3'd0, 7'h2A, 1'b0, 1'b0, lat, nact, bad);
    run_cmd(2'b01, 3'd0, 7'h00, 1'b1, 1'b0, lat, nact, bad);
    n_cmp++;
    if (lat !== 1 || nact !== 0 || bad !== 0) begin
      n_fail++; $display("FAIL zero_timing: got lat %0d act %0d bad %0d want 1/0/0", lat, nact, bad);
    end
    n_cmp++;
    if (sreg !== 7'h2A) begin n_fail++; $display("FAIL zero_value: got %h want 2a", sreg); end
  endtask

  task automatic test_busy_ignore();
    int lat, nact, bad;
    run_cmd(2'b00, 3'd0, 7'h00, 1'b0, 1'b0, lat, nact, bad);
    run_cmd(2'b01, 3'd5, 7'h00, 1'b1, 1'b1, lat, nact, bad);
    n_cmp++;
    if (lat !== 6 || nact !== 5 || bad !== 0) begin
      n_fail++; $display("FAIL busy_poke_timing: got lat %0d act %0d bad %0d want 6/5/0", lat, nact, bad);
    end
    n_cmp++;
    if (sreg !== 7'h1F) begin n_fail++; $display("FAIL busy_poke_value: got %h want 1f", sreg); end
    // start during the done cycle must be dropped
    start = 1'b1; op = 2'b00; load_value = 7'h7F;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if ({ch1, ch0, busy, done} !== 4'b0000) begin
      n_fail++; $display("FAIL done_poke_idle: got %b want 0000", {ch1, ch0, busy, done});
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (sreg !== 7'h1F || busy !== 1'b0) begin
      n_fail++; $display("FAIL done_poke_value: got %h busy %b want 1f busy 0", sreg, busy);
    end
  endtask

  task automatic test_back_to_back();
    int lat, nact, bad;
    run_cmd(2'b00, 3'd0, 7'h03, 1'b0, 1'b0, lat, nact, bad);
    run_cmd(2'b10, 3'd2, 7'h00, 1'b0, 1'b0, lat, nact, bad);
    n_cmp++;
    if (lat !== 3 || sreg !== 7'h00) begin
      n_fail++; $display("FAIL b2b_first: got lat %0d reg %h want 3/00", lat, sreg);
    end
    run_cmd(2'b00, 3'd0, 7'h5A, 1'b0, 1'b0, lat, nact, bad);
    n_cmp++;
    if (lat !== 2 || nact !== 1 || bad !== 0 || sreg !== 7'h5A) begin
      n_fail++; $display("FAIL b2b_second: got lat %0d act %0d bad %0d reg %h want 2/1/0/5a", lat, nact, bad, sreg);
    end
  endtask

  task automatic test_reset_mid();
    int lat, nact, bad;
    run_cmd(2'b00, 3'd0, 7'h01, 1'b0, 1'b0, lat, nact, bad);
    @(negedge clk);
    start = 1'b1; op = 2'b01; amount = 3'd5; serial_in = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (sreg !== 7'h03 || busy !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_pre: got reg %h busy %b want 03/1", sreg, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({ch1, ch0, d, bits, busy, done} !== 12'h000 || sreg !== 7'h07) begin
      n_fail++; $display("FAIL rst_mid_first: got out %h reg %h want 000/07", {ch1, ch0, d, bits, busy, done}, sreg);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({ch1, ch0, busy, done} !== 4'b0000 || sreg !== 7'h07) begin
      n_fail++; $display("FAIL rst_mid_after: got out %b reg %h want 0000/07", {ch1, ch0, busy, done}, sreg);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_shift_up();
    test_shift_down();
    test_rotate();
    test_clamp();
    test_zero_amount();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
